// File: rtl/stc_pe_seq.sv
// Sequencer for one sparse PE row: streams A nonzeros, issues B-row reads and
// time-aligns A values with the returned B row so the PE accumulates D = C + sum(a*B).
module stc_pe_seq #(
    parameter int unsigned DW_DATA = 8,
    parameter int unsigned IDX_W   = 5,
    parameter int unsigned CNT_W   = 6,
    parameter int unsigned RD_LAT  = 1,
    parameter int unsigned MUL_LAT = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [CNT_W-1:0]   nnz,
    input  logic               nz_valid,
    output logic               nz_ready,
    input  logic [DW_DATA-1:0] nz_val,
    input  logic [IDX_W-1:0]   nz_col,
    output logic               b_rd_en,
    output logic [IDX_W-1:0]   b_rd_addr,
    output logic [DW_DATA-1:0] pe_a_element,
    output logic               pe_load_en,
    output logic               pe_acc_en,
    output logic               busy,
    output logic               d_valid
);

    localparam int unsigned LAT  = RD_LAT + MUL_LAT;
    localparam int unsigned DR_W = (LAT > 1) ? $clog2(LAT) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ISSUE,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t                           r_state;
    state_t                           w_next;
    logic [CNT_W-1:0]                 r_nnz;
    logic [CNT_W-1:0]                 r_count;
    logic [DR_W-1:0]                  r_drain;
    logic [RD_LAT-1:0][DW_DATA-1:0]   r_dl_val;
    logic [RD_LAT-1:0]                r_dl_vld;
    logic                             w_hs;
    logic                             w_last;

    assign w_hs   = nz_valid && (r_state == S_ISSUE);
    assign w_last = (r_count == (r_nnz - CNT_W'(1)));

    // State, nonzero count and drain timer
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_nnz   <= '0;
            r_count <= '0;
            r_drain <= '0;
        end else begin
            r_state <= w_next;
            if ((r_state == S_IDLE) && start) begin
                r_nnz   <= nnz;
                r_count <= '0;
            end else if (w_hs) begin
                r_count <= r_count + CNT_W'(1);
            end
            r_drain <= (r_state == S_DRAIN) ? (r_drain + DR_W'(1)) : '0;
        end
    end

    // A-value delay line matching the B-row read latency; runs free so stalls never disturb it
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_dl_val <= '0;
            r_dl_vld <= '0;
        end else begin
            r_dl_val[0] <= w_hs ? nz_val : '0;
            r_dl_vld[0] <= w_hs;
            for (int i = 1; i < int'(RD_LAT); i++) begin
                r_dl_val[i] <= r_dl_val[i-1];
                r_dl_vld[i] <= r_dl_vld[i-1];
            end
        end
    end

    assign pe_a_element = r_dl_vld[RD_LAT-1] ? r_dl_val[RD_LAT-1] : '0;

    // Next state and control outputs
    always_comb begin
        w_next     = r_state;
        nz_ready   = 1'b0;
        b_rd_en    = 1'b0;
        b_rd_addr  = '0;
        pe_load_en = 1'b0;
        pe_acc_en  = 1'b0;
        busy       = 1'b1;
        d_valid    = 1'b0;
        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    w_next = S_LOAD;
                end
            end
            S_LOAD: begin
                pe_load_en = 1'b1;
                w_next     = (r_nnz == '0) ? S_DONE : S_ISSUE;
            end
            S_ISSUE: begin
                nz_ready  = 1'b1;
                pe_acc_en = 1'b1;
                if (w_hs) begin
                    b_rd_en   = 1'b1;
                    b_rd_addr = nz_col;
                    if (w_last) begin
                        w_next = (LAT == 0) ? S_DONE : S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                pe_acc_en = 1'b1;
                if (r_drain == DR_W'(LAT - 1)) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                d_valid = 1'b1;
                w_next  = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

endmodule
